// File: rtl/weight_buf_pkg.sv
// Shared sizing and bank-state encoding for the weight ping-pong buffer.
package weight_buf_pkg;

    localparam int unsigned WORD_W = 324;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned LEN_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        BankEmpty   = 2'd0,
        BankFilling = 2'd1,
        BankFull    = 2'd2
    } bank_state_e;

endpackage

// File: rtl/weight_pingpong_buffer_if.sv
// Fill/read handshake bundle between the width converter, the buffer and the PE array.
interface weight_pingpong_buffer_if;
    import weight_buf_pkg::*;

    logic              fill_start;
    logic [LEN_W-1:0]  fill_len;
    logic              fill_ready;
    logic              valid_in;
    logic [WORD_W-1:0] data_in;
    logic              rd_bank_valid;
    logic [LEN_W-1:0]  rd_len;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              rd_release;
    logic              err;

    modport slave (
        input  fill_start, fill_len, valid_in, data_in, rd_en, rd_addr, rd_release,
        output fill_ready, rd_bank_valid, rd_len, rd_data, rd_data_valid, err
    );

    modport master (
        output fill_start, fill_len, valid_in, data_in, rd_en, rd_addr, rd_release,
        input  fill_ready, rd_bank_valid, rd_len, rd_data, rd_data_valid, err
    );

endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port; both banks share it.
module sdp_ram #(
    parameter int unsigned Width = 324,
    parameter int unsigned AddrW = 9
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [2**AddrW];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Output register holds between reads; only it is reset, never the array.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/weight_pingpong_buffer.sv
// Two-bank weight buffer: one bank fills from the width converter while the PE array reads the other.
module weight_pingpong_buffer
    import weight_buf_pkg::*;
(
    input logic                     clk,
    input logic                     rstn,
    weight_pingpong_buffer_if.slave bus
);

    bank_state_e       bank_st_q [2];
    bank_state_e       bank_st_d [2];
    logic [LEN_W-1:0]  len_q [2];
    logic [LEN_W-1:0]  len_d [2];
    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic              err_q, err_d;
    logic              rd_data_valid_q, rd_data_valid_d;

    logic rd_bank_valid, release_ok, fill_active, len_ok, wr_bank_free;
    logic start_ok, wr_en, last_wr, rd_fire, rd_oob;

    always_comb begin
        rd_bank_valid = (bank_st_q[rd_sel_q] == BankFull);
        release_ok    = bus.rd_release && rd_bank_valid;
        fill_active   = (bank_st_q[wr_sel_q] == BankFilling);
        len_ok        = (bus.fill_len != '0) && (bus.fill_len <= LEN_W'(DEPTH));
        // A release this cycle frees the bank before the grant decision.
        wr_bank_free  = (bank_st_q[wr_sel_q] == BankEmpty) ||
                        (release_ok && (rd_sel_q == wr_sel_q));
        start_ok      = bus.fill_start && wr_bank_free && len_ok;
        wr_en         = bus.valid_in && fill_active;
        last_wr       = wr_en && ({1'b0, wr_cnt_q} == (len_q[wr_sel_q] - LEN_W'(1)));
        rd_fire       = bus.rd_en && rd_bank_valid;
        rd_oob        = rd_fire && ({1'b0, bus.rd_addr} >= len_q[rd_sel_q]);
    end

    always_comb begin
        bank_st_d       = bank_st_q;
        len_d           = len_q;
        wr_sel_d        = wr_sel_q;
        rd_sel_d        = rd_sel_q;
        wr_cnt_d        = wr_cnt_q;
        rd_data_valid_d = rd_fire;
        err_d           = err_q;

        if (release_ok) begin
            bank_st_d[rd_sel_q] = BankEmpty;
            rd_sel_d            = ~rd_sel_q;
        end
        if (start_ok) begin
            bank_st_d[wr_sel_q] = BankFilling;
            len_d[wr_sel_q]     = bus.fill_len;
        end
        if (wr_en) begin
            wr_cnt_d = wr_cnt_q + ADDR_W'(1);
            if (last_wr) begin
                bank_st_d[wr_sel_q] = BankFull;
                wr_cnt_d            = '0;
                wr_sel_d            = ~wr_sel_q;
            end
        end

        if ((bus.fill_start && !start_ok) || (bus.valid_in && !fill_active) ||
            (bus.rd_release && !rd_bank_valid) || rd_oob) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bank_st_q[0]    <= BankEmpty;
            bank_st_q[1]    <= BankEmpty;
            len_q[0]        <= '0;
            len_q[1]        <= '0;
            wr_sel_q        <= 1'b0;
            rd_sel_q        <= 1'b0;
            wr_cnt_q        <= '0;
            err_q           <= 1'b0;
            rd_data_valid_q <= 1'b0;
        end else begin
            bank_st_q       <= bank_st_d;
            len_q           <= len_d;
            wr_sel_q        <= wr_sel_d;
            rd_sel_q        <= rd_sel_d;
            wr_cnt_q        <= wr_cnt_d;
            err_q           <= err_d;
            rd_data_valid_q <= rd_data_valid_d;
        end
    end

    sdp_ram #(
        .Width (WORD_W),
        .AddrW (ADDR_W + 1)
    ) u_ram (
        .clk     (clk),
        .rstn    (rstn),
        .we_i    (wr_en),
        .waddr_i ({wr_sel_q, wr_cnt_q}),
        .wdata_i (bus.data_in),
        .re_i    (rd_fire),
        .raddr_i ({rd_sel_q, bus.rd_addr}),
        .rdata_o (bus.rd_data)
    );

    assign bus.fill_ready    = wr_bank_free;
    assign bus.rd_bank_valid = rd_bank_valid;
    assign bus.rd_len        = rd_bank_valid ? len_q[rd_sel_q] : '0;
    assign bus.rd_data_valid = rd_data_valid_q;
    assign bus.err           = err_q;

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Directed vector bench for the weight ping-pong buffer.
module tb_weight_pingpong_buffer;
    import weight_buf_pkg::*;

    logic clk;
    logic rstn;
    int   total;
    int   passed;

    weight_pingpong_buffer_if bus ();

    weight_pingpong_buffer dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rst; bit fs; int fl; bit vi; int dk; bit re; int ra; bit rr;
        bit fr; bit rbv; int rlen; bit rdv; bit cd; int dx; bit err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [WORD_W-1:0] w(input int k);
        return {8'(k), 308'(0), 8'(k ^ 8'hA5)};
    endfunction

    function automatic void add(input bit rst, input bit fs, input int fl, input bit vi,
                                input int dk, input bit re, input int ra, input bit rr,
                                input bit fr, input bit rbv, input int rlen, input bit rdv,
                                input bit cd, input int dx, input bit err);
        vec_t v;
        v.rst = rst; v.fs = fs; v.fl = fl; v.vi = vi; v.dk = dk; v.re = re; v.ra = ra;
        v.rr = rr; v.fr = fr; v.rbv = rbv; v.rlen = rlen; v.rdv = rdv; v.cd = cd;
        v.dx = dx; v.err = err;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [WORD_W-1:0] act,
                       input logic [WORD_W-1:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic idle();
        bus.fill_start = 1'b0; bus.fill_len = '0; bus.valid_in = 1'b0; bus.data_in = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0; bus.rd_release = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        vec_t v;
        total  = 0;
        passed = 0;
        rstn   = 1'b0;
        idle();

        //  rst fs fl  vi dk  re ra rr | fr rbv rlen rdv cd dx err
        // Single fill of 4 words on alternate cycles, then readback.
        add(0, 1, 4,   0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
        add(0, 0, 0,   1, 1,  0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
        add(0, 0, 0,   0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
        add(0, 0, 0,   1, 2,  0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
        add(0, 0, 0,   0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
        add(0, 0, 0,   1, 3,  0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
        add(0, 0, 0,   0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
        add(0, 0, 0,   1, 4,  0, 0, 0,   1, 1, 4, 0, 0, 0,  0);
        add(0, 0, 0,   0, 0,  1, 0, 0,   1, 1, 4, 1, 1, 1,  0);
        add(0, 0, 0,   0, 0,  1, 1, 0,   1, 1, 4, 1, 1, 2,  0);
        add(0, 0, 0,   0, 0,  1, 3, 0,   1, 1, 4, 1, 1, 4,  0);
        add(0, 0, 0,   0, 0,  1, 2, 0,   1, 1, 4, 1, 1, 3,  0);
        add(0, 0, 0,   0, 0,  0, 0, 0,   1, 1, 4, 0, 1, 3,  0);
        add(0, 0, 0,   0, 0,  0, 0, 1,   1, 0, 0, 0, 0, 0,  0);
        // Overlapped fill/read, both banks full, release+fill in one cycle.
        add(1, 0, 0,   0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 0,  0);
        add(0, 1, 3,   0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
        add(0, 0, 0,   1, 11, 0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
        add(0, 0, 0,   1, 12, 0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
        add(0, 0, 0,   1, 13, 0, 0, 0,   1, 1, 3, 0, 0, 0,  0);
        add(0, 1, 2,   0, 0,  0, 0, 0,   0, 1, 3, 0, 0, 0,  0);
        add(0, 0, 0,   1, 21, 1, 0, 0,   0, 1, 3, 1, 1, 11, 0);
        add(0, 0, 0,   1, 22, 1, 2, 0,   0, 1, 3, 1, 1, 13, 0);
        add(0, 0, 0,   0, 0,  1, 1, 0,   0, 1, 3, 1, 1, 12, 0);
        add(0, 1, 1,   0, 0,  1, 2, 1,   0, 1, 2, 1, 1, 13, 0);
        add(0, 0, 0,   1, 31, 1, 0, 0,   0, 1, 2, 1, 1, 21, 0);
        add(0, 0, 0,   0, 0,  1, 1, 0,   0, 1, 2, 1, 1, 22, 0);
        add(0, 0, 0,   0, 0,  0, 0, 1,   1, 1, 1, 0, 0, 0,  0);
        add(0, 0, 0,   0, 0,  1, 0, 0,   1, 1, 1, 1, 1, 31, 0);
        // Protocol errors.
        add(0, 0, 0,   1, 99, 0, 0, 0,   1, 1, 1, 0, 0, 0,  1);
        add(0, 0, 0,   0, 0,  1, 0, 0,   1, 1, 1, 1, 1, 31, 1);
        add(1, 0, 0,   0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 0,  0);
        add(0, 1, 0,   0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 0,  1);
        add(1, 0, 0,   0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 0,  0);
        add(0, 1, 257, 0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 0,  1);
        add(1, 0, 0,   0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 0,  0);
        add(0, 1, 1,   0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
        add(0, 1, 2,   0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0,  1);
        add(0, 0, 0,   1, 41, 0, 0, 0,   1, 1, 1, 0, 0, 0,  1);
        add(1, 0, 0,   0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 0,  0);
        add(0, 0, 0,   0, 0,  0, 0, 1,   1, 0, 0, 0, 0, 0,  1);
        add(1, 0, 0,   0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 0,  0);
        add(0, 1, 2,   0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
        add(0, 0, 0,   1, 51, 0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
        add(0, 0, 0,   1, 52, 0, 0, 0,   1, 1, 2, 0, 0, 0,  0);
        add(0, 0, 0,   0, 0,  1, 2, 0,   1, 1, 2, 1, 0, 0,  1);
        add(1, 0, 0,   0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 0,  0);
        add(0, 1, 256, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
        // Reset in the middle of a fill, then a clean fill.
        add(1, 0, 0,   0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 0,  0);
        add(0, 1, 4,   0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
        add(0, 0, 0,   1, 61, 0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
        add(0, 0, 0,   1, 62, 0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
        add(1, 0, 0,   0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 0,  0);
        add(0, 1, 4,   0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
        add(0, 0, 0,   1, 71, 0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
        add(0, 0, 0,   1, 72, 0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
        add(0, 0, 0,   1, 73, 0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
        add(0, 0, 0,   1, 74, 0, 0, 0,   1, 1, 4, 0, 0, 0,  0);
        add(0, 0, 0,   0, 0,  1, 0, 0,   1, 1, 4, 1, 1, 71, 0);
        add(0, 0, 0,   0, 0,  1, 3, 0,   1, 1, 4, 1, 1, 74, 0);
        add(0, 0, 0,   0, 0,  0, 0, 0,   1, 1, 4, 0, 1, 74, 0);

        // Reset values.
        do_reset();
        chk("rst.fill_ready", WORD_W'(bus.fill_ready), WORD_W'(1));
        chk("rst.rd_bank_valid", WORD_W'(bus.rd_bank_valid), '0);
        chk("rst.rd_len", WORD_W'(bus.rd_len), '0);
        chk("rst.rd_data", bus.rd_data, '0);
        chk("rst.rd_data_valid", WORD_W'(bus.rd_data_valid), '0);
        chk("rst.err", WORD_W'(bus.err), '0);

        foreach (vecs[i]) begin
            v = vecs[i];
            if (v.rst) begin
                do_reset();
            end else begin
                bus.fill_start = v.fs;  bus.fill_len = LEN_W'(v.fl);
                bus.valid_in   = v.vi;  bus.data_in  = w(v.dk);
                bus.rd_en      = v.re;  bus.rd_addr  = ADDR_W'(v.ra);
                bus.rd_release = v.rr;
                tick();
            end
            chk($sformatf("v%0d.fill_ready", i), WORD_W'(bus.fill_ready), WORD_W'(v.fr));
            chk($sformatf("v%0d.rd_bank_valid", i), WORD_W'(bus.rd_bank_valid),
                WORD_W'(v.rbv));
            chk($sformatf("v%0d.rd_len", i), WORD_W'(bus.rd_len), WORD_W'(v.rlen));
            chk($sformatf("v%0d.rd_data_valid", i), WORD_W'(bus.rd_data_valid),
                WORD_W'(v.rdv));
            chk($sformatf("v%0d.err", i), WORD_W'(bus.err), WORD_W'(v.err));
            if (v.cd) chk($sformatf("v%0d.rd_data", i), bus.rd_data, w(v.dx));
        end

        // Same-cycle release grants the freed bank combinationally, then
        // a final fill write coincides with release of the other bank.
        do_reset();
        bus.fill_start = 1'b1; bus.fill_len = LEN_W'(1); tick();
        bus.valid_in = 1'b1; bus.data_in = w(81); tick();
        bus.fill_start = 1'b1; bus.fill_len = LEN_W'(1); tick();
        bus.valid_in = 1'b1; bus.data_in = w(82); tick();
        chk("both_full.fill_ready", WORD_W'(bus.fill_ready), '0);
        bus.rd_release = 1'b1; bus.fill_start = 1'b1; bus.fill_len = LEN_W'(1);
        #1;
        chk("rel_comb.fill_ready", WORD_W'(bus.fill_ready), WORD_W'(1));
        tick();
        chk("rel_grant.fill_ready", WORD_W'(bus.fill_ready), '0);
        chk("rel_grant.rd_bank_valid", WORD_W'(bus.rd_bank_valid), WORD_W'(1));
        chk("rel_grant.err", WORD_W'(bus.err), '0);
        bus.valid_in = 1'b1; bus.data_in = w(83); bus.rd_release = 1'b1; tick();
        chk("wr_rel.rd_bank_valid", WORD_W'(bus.rd_bank_valid), WORD_W'(1));
        chk("wr_rel.rd_len", WORD_W'(bus.rd_len), WORD_W'(1));
        chk("wr_rel.fill_ready", WORD_W'(bus.fill_ready), WORD_W'(1));
        bus.rd_en = 1'b1; bus.rd_addr = '0; tick();
        chk("wr_rel.rd_data_valid", WORD_W'(bus.rd_data_valid), WORD_W'(1));
        chk("wr_rel.rd_data", bus.rd_data, w(83));
        chk("wr_rel.err", WORD_W'(bus.err), '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
